// File: rtl/spi_master.sv
// SPI master: 8-bit full-duplex transfers in all four CPOL/CPHA modes.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first TX and RX bit order.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [7:0] data_in,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCLK,
  output logic       CS,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx
);

  localparam int DW = $clog2(CLK_DIV + 1);

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [4:0]      edge_q;
  logic [7:0]      tx_q;
  logic [7:0]      rx_q;
  logic            cpol_q;
  logic            cpha_q;

  logic            tick;
  logic [4:0]      edge_d;
  logic            lead_edge;
  logic            samp;
  logic            last;
  logic [7:0]      tx_d;
  logic [7:0]      rx_d;
  logic            tx_bit;
  logic            tx_nxt;
  logic            first_bit;

  always_comb begin
    tick      = (div_q == DW'(CLK_DIV));
    edge_d    = edge_q + 5'd1;
    lead_edge = edge_d[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing ones
    samp      = lead_edge ^ cpha_q;
    last      = (edge_d == 5'd16);
    tx_d      = LsbFirst ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
    rx_d      = LsbFirst ? {MISO, rx_q[7:1]} : {rx_q[6:0], MISO};
    tx_bit    = LsbFirst ? tx_q[0] : tx_q[7];
    tx_nxt    = LsbFirst ? tx_d[0] : tx_d[7];
    first_bit = LsbFirst ? data_in[0] : data_in[7];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      MOSI    <= 1'b0;
      SCLK    <= 1'b0;
      CS      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          CS   <= 1'b1;
          MOSI <= 1'b0;
          busy <= 1'b0;
          SCLK <= mode[1];
          if (load) begin
            tx_q    <= data_in;
            cpol_q  <= mode[1];
            cpha_q  <= mode[0];
            div_q   <= DW'(1);
            edge_q  <= '0;
            CS      <= 1'b0;
            busy    <= 1'b1;
            MOSI    <= mode[0] ? 1'b0 : first_bit;
            state_q <= LEAD;
          end
        end
        LEAD, SHIFT: begin
          if (tick) begin
            div_q  <= DW'(1);
            SCLK   <= ~SCLK;
            edge_q <= edge_d;
            if (samp) begin
              rx_q <= rx_d;
            end else if (!last) begin
              // CPHA=1 puts out the current bit, CPHA=0 the following one
              MOSI <= cpha_q ? tx_bit : tx_nxt;
              tx_q <= tx_d;
            end
            state_q <= last ? TRAIL : SHIFT;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        TRAIL: begin
          SCLK <= cpol_q;
          if (tick) begin
            CS      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            MOSI    <= 1'b0;
            rx      <= rx_q;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: vector table, slave model, scoreboard.
// Honours SPI_MASTER_LSB_FIRST_EN for expected first MOSI bit.
module tb_spi_master;

  localparam int D   = 4;
  localparam int LAT = 1 + 17 * D;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       MISO;
  logic       MOSI;
  logic       SCLK;
  logic       CS;
  logic       busy;
  logic       done;
  logic [7:0] rx;

  always #5 CLK = ~CLK;

  spi_master #(.CLK_DIV(D)) dut (
    .CLK(CLK), .RST(RST), .mode(mode), .load(load),
    .data_in(data_in), .MISO(MISO), .MOSI(MOSI),
    .SCLK(SCLK), .CS(CS), .busy(busy), .done(done), .rx(rx)
  );

  logic       loop_en = 1'b0;
  logic       sl_miso = 1'b0;
  logic [1:0] sl_mode = 2'b00;
  logic [7:0] sl_byte = 8'h00;
  logic [7:0] sl_sh   = 8'h00;
  logic [7:0] sl_cap  = 8'h00;
  logic       sclk_p  = 1'b0;
  logic       cs_p    = 1'b1;

  assign MISO = loop_en ? MOSI : sl_miso;

  function automatic logic msb(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  function automatic logic [7:0] shl(input logic [7:0] b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {1'b0, b[7:1]};
`else
    return {b[6:0], 1'b0};
`endif
  endfunction

  function automatic logic [7:0] shin(input logic [7:0] c, input logic v);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {v, c[7:1]};
`else
    return {c[6:0], v};
`endif
  endfunction

  // Slave responder: reacts on the negedge after each SCLK transition
  always @(negedge CLK) begin
    sclk_p <= SCLK;
    cs_p   <= CS;
    if (CS === 1'b1) begin
      sl_sh   <= sl_mode[0] ? sl_byte : shl(sl_byte);
      sl_miso <= msb(sl_byte);
    end else if (CS === 1'b0) begin
      if (cs_p === 1'b1) sl_cap <= 8'h00;
      if (SCLK !== sclk_p) begin
        if ((SCLK !== sl_mode[1]) ^ sl_mode[0]) begin
          sl_cap <= shin(sl_cap, MOSI);
        end else begin
          sl_miso <= msb(sl_sh);
          sl_sh   <= shl(sl_sh);
        end
      end
    end
  end

  typedef struct {
    logic [7:0] rx;
    logic [7:0] sl;
    bit         chk_sl;
  } exp_t;

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] slb;
    bit         lp;
    logic [7:0] erx;
    logic [7:0] esl;
  } vec_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic sclk0;
  logic exp_m0;
  logic cur_cpha;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic [7:0] d,
                       input logic [7:0] slb, input bit lp,
                       input logic [7:0] erx, input logic [7:0] esl,
                       input bit quick);
    exp_t e;
    if (!quick) begin
      mode    = m;
      sl_mode = m;
      sl_byte = slb;
      loop_en = lp;
      @(negedge CLK);
      @(negedge CLK);
      chk("sclk_idle", SCLK, m[1]);
    end
    sclk0    = SCLK;
    cur_cpha = m[0];
    exp_m0   = msb(d);
    data_in  = d;
    load     = 1'b1;
    e.rx     = erx;
    e.sl     = esl;
    e.chk_sl = !lp;
    sb.push_back(e);
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic finish(input int pulse_at);
    int   n;
    int   last;
    int   tog;
    int   bad;
    int   both;
    logic prev;
    exp_t e;
    prev = sclk0;
    last = 1;
    tog  = 0;
    bad  = 0;
    both = 0;
    for (n = 1; n < LAT + 40; n++) begin
      if (n == 1) begin
        chk("cs_low", CS, 0);
        chk("busy_high", busy, 1);
        if (!cur_cpha) chk("mosi_first_bit", MOSI, exp_m0);
      end
      if (SCLK !== prev) begin
        tog++;
        if (n - last != D) bad++;
        last = n;
        prev = SCLK;
      end
      if (busy && done) both++;
      if (done === 1'b1) break;
      if (n == pulse_at) begin
        data_in = 8'hFF;
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge CLK);
    end
    chk("latency", n, LAT);
    chk("toggles", tog, 16);
    chk("edge_spacing", bad + ((n - last != D) ? 1 : 0), 0);
    chk("busy_done_overlap", both, 0);
    chk("cs_high_at_done", CS, 1);
    chk("busy_low_at_done", busy, 0);
    chk("mosi_low_at_done", MOSI, 0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty_at_done", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("rx", rx, e.rx);
      if (e.chk_sl) chk("slave_capture", sl_cap, e.sl);
    end
  endtask

  vec_t vt[6];
  int   extra;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b00, 8'hB3, 8'h00, 1'b1, 8'hB3, 8'h00};
    vt[1] = '{2'b11, 8'hB3, 8'hCA, 1'b0, 8'hCA, 8'hB3};
    vt[2] = '{2'b01, 8'h5A, 8'h3C, 1'b0, 8'h3C, 8'h5A};
    vt[3] = '{2'b10, 8'h5A, 8'h3C, 1'b0, 8'h3C, 8'h5A};
    vt[4] = '{2'b00, 8'h0F, 8'hA5, 1'b0, 8'hA5, 8'h0F};
    vt[5] = '{2'b11, 8'h6E, 8'h00, 1'b1, 8'h6E, 8'h00};

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_cs", CS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx, 0);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start(vt[i].m, vt[i].d, vt[i].slb, vt[i].lp,
            vt[i].erx, vt[i].esl, 1'b0);
      finish(0);
    end

    start(2'b00, 8'h69, 8'h81, 1'b0, 8'h81, 8'h69, 1'b0);
    finish(20);
    extra = 0;
    repeat (80) begin
      @(negedge CLK);
      if (done === 1'b1) extra++;
    end
    chk("single_done", extra, 0);
    chk("idle_after_ignored_load", busy, 0);

    start(2'b10, 8'h96, 8'h5C, 1'b0, 8'h5C, 8'h96, 1'b0);
    void'(sb.pop_back());
    repeat (29) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_cs", CS, 1);
    chk("midrst_sclk", SCLK, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx", rx, 0);
    chk("midrst_done", done, 0);
    RST = 1'b0;
    extra = 0;
    repeat (100) begin
      @(negedge CLK);
      if (done === 1'b1) extra++;
    end
    chk("no_done_after_rst", extra, 0);
    start(2'b10, 8'h96, 8'h5C, 1'b0, 8'h5C, 8'h96, 1'b0);
    finish(0);

    start(2'b00, 8'hC4, 8'h00, 1'b1, 8'hC4, 8'h00, 1'b0);
    finish(0);
    start(2'b00, 8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1);
    chk("b2b_cs_high_one_cycle", CS, 0);
    finish(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
